// File: rtl/ibex_dummy_seed_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ibex_dummy_seed_ctrl                                         |
// | Description : Reseed controller for dummy-instruction insertion. Counts    |
// |               consumed dummy instructions, fetches a fresh seed from the   |
// |               entropy source and delivers it as a one-cycle strobe.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ibex_dummy_seed_ctrl #(
  parameter int unsigned RESEED_CNT_W = 16,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    dummy_instr_en_i,
  input  logic [RESEED_CNT_W-1:0] reseed_interval_i,
  input  logic                    reseed_force_i,
  input  logic                    insert_dummy_instr_i,
  input  logic                    id_in_ready_i,
  output logic                    edn_req_o,
  input  logic                    edn_ack_i,
  input  logic [31:0]             edn_data_i,
  output logic                    dummy_instr_seed_en_o,
  output logic [31:0]             dummy_instr_seed_o,
  output logic                    reseed_busy_o,
  output logic                    seed_err_o
);

  localparam int unsigned TIMER_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    APPLY = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [RESEED_CNT_W-1:0] cnt_q, cnt_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [31:0]             seed_q, seed_d;
  logic                    force_pending_q, force_pending_d;
  logic                    err_q, err_d;

  logic event_seen;
  logic interval_on;
  logic interval_hit;
  logic trigger;
  logic seed_strobe;

  assign event_seen   = insert_dummy_instr_i & id_in_ready_i & dummy_instr_en_i;
  assign interval_on  = (reseed_interval_i != '0);
  // >= rather than == so lowering the interval below the count still fires
  assign interval_hit = interval_on & (cnt_q >= reseed_interval_i);
  assign trigger      = force_pending_q | reseed_force_i | interval_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      timer_q         <= '0;
      seed_q          <= '0;
      force_pending_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      timer_q         <= timer_d;
      seed_q          <= seed_d;
      force_pending_q <= force_pending_d;
      err_q           <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    timer_d         = timer_q;
    seed_d          = seed_q;
    force_pending_d = force_pending_q | reseed_force_i;
    err_d           = err_q;
    edn_req_o       = 1'b0;
    seed_strobe     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          // A force arriving in the same cycle is absorbed by this request
          state_d         = REQ;
          cnt_d           = '0;
          timer_d         = '0;
          force_pending_d = 1'b0;
        end else if (event_seen && interval_on && (cnt_q != '1)) begin
          cnt_d = cnt_q + RESEED_CNT_W'(1);
        end
      end
      REQ: begin
        edn_req_o = 1'b1;
        timer_d   = timer_q + TIMER_W'(1);
        if (edn_ack_i) begin
          seed_d  = edn_data_i;
          state_d = APPLY;
        end else if (timer_q == TIMER_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      APPLY: begin
        seed_strobe = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dummy_instr_seed_en_o = seed_strobe;
  assign dummy_instr_seed_o    = seed_strobe ? seed_q : 32'h0;
  assign reseed_busy_o         = (state_q != IDLE);
  assign seed_err_o            = err_q;

endmodule
`default_nettype wire

// File: doc/ibex_dummy_seed_ctrl.md
# ibex_dummy_seed_ctrl

Reseed controller for the dummy-instruction insertion logic. It counts consumed dummy instructions and fetches a fresh 32-bit seed from the entropy source over a req/ack handshake, either periodically or on a software-forced request. It then delivers the seed to the dummy-instruction block as a single-cycle `dummy_instr_seed_en_o`/`dummy_instr_seed_o` strobe. It sits upstream of the dummy-instruction block and is driven by the CSR file and the ID stage.

## Interface
- `RESEED_CNT_W`, default 16: width of the reseed interval and of the event counter.
- `ACK_TIMEOUT`, default 255: maximum cycles `edn_req_o` stays high without an ack. Legal range is 1 or more; the timer width is $clog2(ACK_TIMEOUT+1).
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `dummy_instr_en_i`, in, 1: dummy insertion enabled (CSR).
- `reseed_interval_i`, in, RESEED_CNT_W: number of consumed dummy instructions between automatic reseeds. 0 disables automatic reseed.
- `reseed_force_i`, in, 1: single-cycle software reseed request (CSR write).
- `insert_dummy_instr_i`, in, 1: dummy instruction currently presented.
- `id_in_ready_i`, in, 1: ID stage accepting.
- `edn_req_o`, out, 1: entropy request.
- `edn_ack_i`, in, 1: entropy ack; `edn_data_i` is valid in the same cycle.
- `edn_data_i`, in, 32: entropy word.
- `dummy_instr_seed_en_o`, out, 1: seed-update strobe.
- `dummy_instr_seed_o`, out, 32: seed value. It is 0 whenever the strobe is low.
- `reseed_busy_o`, out, 1: FSM is not in IDLE.
- `seed_err_o`, out, 1: sticky entropy-timeout error.

## Operation
- **States:** IDLE, REQ, APPLY. Reset state is IDLE.
- **Reset values of registers:** event counter = 0, timer = 0, seed register = 0, force_pending = 0, err = 0.
- **Event:** `insert_dummy_instr_i & id_in_ready_i & dummy_instr_en_i`. It increments the counter only in IDLE. Events in REQ and APPLY are dropped.
- **Counter width:** the counter saturates at all-ones and never wraps. When `reseed_interval_i` == 0 the counter holds its value.
- **Force pending:** `reseed_force_i` sets force_pending in any state. force_pending clears when the FSM leaves IDLE for REQ. Only one request is queued; further forces while pending are merged into it.
- **IDLE → REQ** when either:
  - force_pending is set or `reseed_force_i` is high, or
  - `reseed_interval_i` != 0 and counter >= `reseed_interval_i`. The >= comparison covers the interval being lowered below the current count.
  - On this transition the counter clears to 0 and the timer clears to 0.
- **REQ:**
  - `edn_req_o` = 1 and the timer increments each cycle.
  - On `edn_ack_i`: capture `edn_data_i` into the seed register and go to APPLY.
  - Otherwise, when timer == ACK_TIMEOUT-1: go to IDLE and set err. The seed register is unchanged.
  - Ack in the timeout cycle: ack wins and err is not set.
- **APPLY:** `dummy_instr_seed_en_o` = 1 and `dummy_instr_seed_o` = seed register, for exactly one cycle. Then go to IDLE.
- `edn_ack_i` outside REQ is ignored.
- Deasserting `dummy_instr_en_i` does not abort REQ or APPLY; the handshake completes normally. Forced reseeds work with insertion disabled.
- `seed_err_o` is cleared only by reset.
- `reseed_busy_o` = (state != IDLE).

## Timing
- **Reset values of outputs:** all 0.
- **Start of request:** if the trigger is true in IDLE at cycle t, `edn_req_o` is high from t+1.
- **Ack:** ack sampled at cycle a gives the seed strobe at a+1 and IDLE at a+2. A new trigger can be accepted in IDLE at a+2.
- **Timeout:** `edn_req_o` is high for exactly ACK_TIMEOUT cycles. `seed_err_o` rises in the first cycle after `edn_req_o` falls, the same cycle the FSM is back in IDLE.
- **Event counting:** an event at cycle t is visible in the counter at t+1. An interval match at t+1 gives REQ at t+2.
- **Force:** a force at cycle t while in IDLE gives REQ at t+1.
- **Mid-operation reset:** asynchronous reset returns the FSM to IDLE immediately. `edn_req_o` and the seed strobe drop in the same cycle, with no pending state retained.

## Test plan
- **Periodic reseed:** interval=3, enable=1. Three consumed dummy instructions → `edn_req_o` two cycles after the third. Ack with data 0xDEADBEEF → one-cycle strobe with seed 0xDEADBEEF; counter back at 0.
- **Interval 0:** interval=0 with 100 events → no request. Then `reseed_force_i` pulse → request next cycle. Ack 0x12345678 → strobe carries 0x12345678.
- **Timeout:** ACK_TIMEOUT=4, force, ack never arrives → req high for exactly 4 cycles, `seed_err_o`=1 afterwards and sticky. A later force with ack still delivers the seed and err stays 1.
- **Simultaneous ack and timeout:** ack exactly in the last timeout cycle → strobe occurs and err=0.
- **Forces while busy:** two forces during REQ → exactly one additional REQ after returning to IDLE. Events during REQ and APPLY are not counted.
- **Reset mid-REQ:** reset asserted mid-REQ → outputs 0 asynchronously. After release, ack pulses are ignored and there is no strobe.
